// File: rtl/scrambler_pkg.sv
// Shared definitions for the serial scrambler packer: default widths and
// the packer FSM state encoding, reused by the polynomial mux and neighbours.
package scrambler_pkg;

  // Scrambled word width; equals the polynomial-data width.
  localparam int WORD_W = 16;
  // Polynomial-select width (32 selections).
  localparam int SEL_W  = 5;

  // Packer FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAD     = 2'd2
  } state_e;

endpackage

// File: rtl/scrambler_out_reg.sv
// One-entry output register with valid/ready handshake. It holds a word
// until the consumer takes it and can reload on the same edge it drains.
module scrambler_out_reg #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // While valid is high and ready is low, valid and data hold steady.
  // Ready on the input side is high when the register is empty or draining.

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Load a new word when space exists; otherwise clear valid after a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/scrambler_serial_packer.sv
// Serial-to-parallel packer that XORs each completed word with polynomial
// data selected by pd_sel. Partial final words are zero-padded in the LSBs.
module scrambler_serial_packer #(
  parameter int WORD_W = scrambler_pkg::WORD_W,
  parameter int SEL_W  = scrambler_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [SEL_W-1:0]  pd_sel,
  input  logic [WORD_W-1:0] polydata,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic [1:0]        state_o
);

  import scrambler_pkg::*;

  // Handshake: din is taken on an edge where din_valid && din_ready; dout is
  // taken on an edge where dout_valid && dout_ready, and holds otherwise.

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORD_W-1:0]   shreg_q;
  logic [SEL_W-1:0]    pd_sel_q;

  logic                out_in_ready;
  logic                accept;
  logic                word_done;
  logic                load_valid;
  logic [WORD_W-1:0]   shifted;
  logic [CNT_W:0]      pad_shift;
  logic [WORD_W-1:0]   load_word_d;
  logic                load_last_d;

  // Datapath for the word about to be loaded and the input-side handshake.
  always_comb begin
    shifted     = {shreg_q[WORD_W-2:0], din};
    // Held bits sit in the LSBs; shifting left moves the first bit to the MSB
    // and pushes any stale bits out the top.
    pad_shift   = (CNT_W+1)'(WORD_W) - {1'b0, cnt_q};
    // Only the completing bit needs room in the output register.
    din_ready   = (state_q == COLLECT) && !((cnt_q == CNT_LAST) && !out_in_ready);
    accept      = din_valid && din_ready;
    word_done   = accept && (cnt_q == CNT_LAST);
    load_valid  = word_done || ((state_q == PAD) && out_in_ready);
    load_word_d = ((state_q == PAD) ? (shreg_q << pad_shift) : shifted) ^ polydata;
    load_last_d = (state_q == PAD) ? 1'b1 : din_last;
  end

  // Packer FSM: frame start, bit collection and padding of a partial word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      pd_sel_q <= '0;
    end else begin
      // pd_sel only moves when a word loads, so polydata stays settled.
      if (load_valid) begin
        pd_sel_q <= pd_sel_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            shreg_q  <= '0;
            pd_sel_q <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            shreg_q <= shifted;
            cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
            if (din_last) begin
              state_q <= word_done ? IDLE : PAD;
            end
          end
        end
        PAD: begin
          if (out_in_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  scrambler_out_reg #(
    .DATA_W(WORD_W + 1)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (load_valid),
    .in_ready_o  (out_in_ready),
    .in_data_i   ({load_last_d, load_word_d}),
    .out_valid_o (dout_valid),
    .out_data_o  ({dout_last, dout}),
    .out_ready_i (dout_ready)
  );

  assign pd_sel  = pd_sel_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_scrambler_serial_packer.sv
// Directed bench for scrambler_serial_packer with a stub polynomial mux
// returning pd_sel * 0x0101 and an in-order scoreboard on dout.
module tb_scrambler_serial_packer;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 5;

  logic              clk;
  logic              rst;
  logic              frame_start;
  logic              din;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic [SEL_W-1:0]  pd_sel;
  logic [WORD_W-1:0] polydata;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_last;
  logic              dout_ready;
  logic [1:0]        state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_W:0] exp_q[$];

  // Polynomial mux stub: pd_sel * 0x0101.
  assign polydata = {3'd0, pd_sel, 3'd0, pd_sel};

  scrambler_serial_packer #(
    .WORD_W(WORD_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .din         (din),
    .din_valid   (din_valid),
    .din_last    (din_last),
    .din_ready   (din_ready),
    .pd_sel      (pd_sel),
    .polydata    (polydata),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_ready  (dout_ready),
    .state_o     (state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b, input logic last);
    int waited = 0;
    din       = b;
    din_valid = 1'b1;
    din_last  = last;
    while (din_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check("din_accept", 32'(din_ready), 32'd1);
    tick();
    din       = 1'b0;
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] val, input int n, input logic last);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(val[i], last && (i == 0));
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Scoreboard: every transferred word must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("sb_word", 32'({dout_last, dout}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0]        kb;
    logic [4:0]        p;
    logic [WORD_W-1:0] d;
    int                waited;

    rst         = 1'b0;
    frame_start = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    din_last    = 1'b0;
    dout_ready  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout_last",  32'(dout_last),  32'd0);
    check("rst_din_ready",  32'(din_ready),  32'd0);
    check("rst_pd_sel",     32'(pd_sel),     32'd0);
    check("rst_state",      32'(state_o),    32'd0);
    rst = 1'b1;
    tick();
    check("idle_din_ready", 32'(din_ready), 32'd0);

    // One-word frame 0xA5A5 with pd_sel 0
    start_frame();
    check("t1_state_collect", 32'(state_o), 32'd1);
    check("t1_pd_sel_start",  32'(pd_sel),  32'd0);
    exp_q.push_back({1'b1, 16'hA5A5});
    send_bits(16'hA5A5, 16, 1'b1);
    check("t1_dout_valid", 32'(dout_valid), 32'd1);
    check("t1_dout",       32'(dout),       32'hA5A5);
    check("t1_dout_last",  32'(dout_last),  32'd1);
    check("t1_state_idle", 32'(state_o),    32'd0);
    check("t1_pd_sel_end", 32'(pd_sel),     32'd1);
    tick();
    check("t1_valid_clear", 32'(dout_valid), 32'd0);

    // 33 words streamed: pd_sel walks 0..31 then wraps to 0
    start_frame();
    for (int k = 0; k < 33; k++) begin
      kb = 8'(k);
      p  = 5'(k % 32);
      d  = {kb, ~kb};
      check("t2_pd_sel", 32'(pd_sel), 32'(p));
      exp_q.push_back({(k == 32), d ^ {3'd0, p, 3'd0, p}});
      send_bits(d, 16, (k == 32));
    end
    check("t2_pd_sel_end", 32'(pd_sel), 32'd1);

    // Output stall of 20 cycles during the second word
    start_frame();
    exp_q.push_back({1'b0, 16'h1357});
    exp_q.push_back({1'b0, 16'h2569});
    exp_q.push_back({1'b1, 16'hFDFD});
    send_bits(16'h1357, 16, 1'b0);
    dout_ready = 1'b0;
    check("t3_word1_valid", 32'(dout_valid), 32'd1);
    send_bits(16'h1234, 15, 1'b0);
    din       = 1'b0;
    din_valid = 1'b1;
    #1;
    check("t3_din_ready_drop", 32'(din_ready), 32'd0);
    repeat (5) tick();
    check("t3_din_ready_held", 32'(din_ready),  32'd0);
    check("t3_dout_held",      32'(dout),       32'h1357);
    check("t3_valid_held",     32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    #1;
    check("t3_din_ready_back", 32'(din_ready), 32'd1);
    send_bit(1'b0, 1'b0);
    send_bits(16'hFFFF, 16, 1'b1);

    // Partial final word 10110 padded in the LSBs
    start_frame();
    exp_q.push_back({1'b0, 16'h0F0F});
    exp_q.push_back({1'b1, 16'hB101});
    send_bits(16'h0F0F, 16, 1'b0);
    send_bits(16'h0016, 5, 1'b1);
    check("t4_state_pad",     32'(state_o),    32'd2);
    check("t4_din_ready_pad", 32'(din_ready),  32'd0);
    check("t4_valid_pre",     32'(dout_valid), 32'd0);
    tick();
    check("t4_state_idle", 32'(state_o),    32'd0);
    check("t4_dout_valid", 32'(dout_valid), 32'd1);
    check("t4_dout",       32'(dout),       32'hB101);
    check("t4_dout_last",  32'(dout_last),  32'd1);
    check("t4_pd_sel",     32'(pd_sel),     32'd2);

    // Reset mid-frame discards the held word and partial bits
    start_frame();
    dout_ready = 1'b0;
    send_bits(16'hAAAA, 16, 1'b0);
    send_bits(16'h01FF, 9, 1'b0);
    check("t5_pre_valid",  32'(dout_valid), 32'd1);
    check("t5_pre_pd_sel", 32'(pd_sel),     32'd1);
    rst = 1'b0;
    tick();
    check("t5_rst_dout",       32'(dout),       32'd0);
    check("t5_rst_dout_valid", 32'(dout_valid), 32'd0);
    check("t5_rst_dout_last",  32'(dout_last),  32'd0);
    check("t5_rst_din_ready",  32'(din_ready),  32'd0);
    check("t5_rst_pd_sel",     32'(pd_sel),     32'd0);
    check("t5_rst_state",      32'(state_o),    32'd0);
    rst        = 1'b1;
    dout_ready = 1'b1;
    repeat (4) tick();
    check("t5_quiet", 32'(dout_valid), 32'd0);
    start_frame();
    exp_q.push_back({1'b1, 16'h00F0});
    send_bits(16'h00F0, 16, 1'b1);
    check("t5_new_dout", 32'(dout), 32'h00F0);

    // Wait for the scoreboard to drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      tick();
      waited++;
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scrambler_serial_packer.md
SCRAMBLER_SERIAL_PACKER -- requirements
Module: scrambler_serial_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 16: scrambled word width; equals the polynomial-data width.
REQ-002 SHALL have parameter SEL_W, default 5: polynomial-select width (32 selections).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port frame_start, input, 1: a pulse in IDLE starts a frame; ignored in other states.
REQ-006 SHALL have port din, input, 1: serial plaintext bit.
REQ-007 SHALL have port din_valid, input, 1: din is valid.
REQ-008 SHALL have port din_last, input, 1: qualifies the final bit of a frame (meaningful only with din_valid).
REQ-009 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-010 SHALL have port pd_sel, output, SEL_W: select driven to the polynomial-data mux.
REQ-011 SHALL have port polydata, input, WORD_W: combinational mux return for the current pd_sel.
REQ-012 SHALL have port dout, output, WORD_W: scrambled word.
REQ-013 SHALL have port dout_valid, output, 1: dout holds a word.
REQ-014 SHALL have port dout_last, output, 1: dout is the final word of the frame.
REQ-015 SHALL have port dout_ready, input, 1: the consumer takes dout.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, COLLECT, PAD.
- IDLE -> COLLECT on frame_start.
- COLLECT -> IDLE on acceptance of a din_last bit that completes a word.
- COLLECT -> PAD on acceptance of a din_last bit with a partial word.
- PAD -> IDLE when the padded word is loaded.
REQ-017 SHALL accept a bit only on din_valid && din_ready; din_ready SHALL be 0 in IDLE and PAD.
REQ-018 SHALL shift accepted bits into a WORD_W shift register, first bit at MSB; a 4-bit counter SHALL track bits held.
REQ-019 SHALL complete a word on acceptance of the 16th bit.
REQ-020 SHALL, on word completion, load dout on the same edge with {shreg[14:0],din} XOR polydata, set dout_valid, and increment pd_sel modulo 2^SEL_W (31 -> 0).
- Latency: 1 cycle from the 16th accepted bit to dout_valid.
REQ-021 SHALL, in PAD, zero-fill the remaining LSBs, XOR with polydata, load dout with dout_last=1, and increment pd_sel, in one cycle when the output register is free.
REQ-022 SHALL hold pd_sel stable between word completions so that polydata is settled when sampled.
REQ-023 SHALL keep dout/dout_valid/dout_last stable while dout_valid && !dout_ready.
- dout_valid SHALL clear after a transfer unless a new word loads on the same edge.
REQ-024 SHALL drive din_ready=0 in COLLECT only when the bit count is 15, dout_valid=1 and dout_ready=0 (the output register is full and not draining); a load while draining SHALL be lossless.
REQ-025 SHALL reset pd_sel to 0 on frame_start in IDLE; pd_sel SHALL otherwise persist across frames.
REQ-026 SHALL emit no word for a frame_start immediately followed by IDLE (empty frame impossible: din_last requires a bit).

Reset
REQ-027 SHALL, when rst=0 at a clock edge, set: state=IDLE, bit count=0, shreg=0, pd_sel=0, dout=0, dout_valid=0, dout_last=0, din_ready=0.
REQ-028 SHALL discard a partial word or undelivered dout on reset mid-frame; no output SHALL follow until the next frame_start.

Structure
REQ-029 SHALL place WORD_W, SEL_W and the FSM state encoding in shared package scrambler_pkg, reused by the mux and its neighbours.
REQ-030 SHALL implement the output register/handshake as sub-module scrambler_out_reg (1-entry valid/ready skid, WORD_W+1 data).

Verification
REQ-031 SHALL cover: frame of 16 bits 0xA5A5, polydata stub = pd_sel*0x0101, dout_ready=1 -> dout=0xA5A5 (pd_sel 0), dout_last=1, pd_sel=1 after.
REQ-032 SHALL cover: 33 words streamed -> pd_sel sequence 0..31,0; word 33 XORed with polydata for pd_sel 0.
REQ-033 SHALL cover: dout_ready=0 for 20 cycles during a 2nd word -> din_ready drops at bit 15; no bit lost; words in order.
REQ-034 SHALL cover: din_last on bit 5 (bits 10110) -> PAD; dout = 0xB000 XOR polydata, dout_last=1, state IDLE.
REQ-035 SHALL cover: rst=0 asserted at bit 9 -> all outputs 0; next frame's first word uses pd_sel 0 and contains no stale bits.
